// File: rtl/bn_pkg.sv
// Shared types and defaults for the batch-mean controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bn_pkg;

    localparam int BN_IL    = 4;
    localparam int BN_FL    = 16;
    localparam int BN_W     = BN_IL + BN_FL;
    localparam int BN_AW    = 2 * BN_W;
    localparam int BN_NUM_W = 5;

    typedef logic signed [BN_W-1:0]  sample_t;
    typedef logic signed [BN_AW-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DIV   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bn_mean_ctrl_if.sv
// Handshake bundle between a sample producer and the batch-mean controller.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the sample path; results are strobes.
interface bn_mean_ctrl_if
    import bn_pkg::*;
#(
    parameter int IL = BN_IL,
    parameter int FL = BN_FL
) ();

    logic                      start;
    logic [BN_NUM_W-1:0]       num;
    logic                      in_valid;
    logic signed [IL+FL-1:0]   in_data;
    logic                      in_ready;
    logic                      busy;
    logic                      out_valid;
    logic signed [IL+FL-1:0]   out_data;
    logic                      err;

    modport master (
        output start, num, in_valid, in_data,
        input  in_ready, busy, out_valid, out_data, err
    );

    modport slave (
        input  start, num, in_valid, in_data,
        output in_ready, busy, out_valid, out_data, err
    );

endinterface

// File: rtl/bn_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle over AW cycles.
// Latency: done is high in the cycle of the final iteration; quotient valid from the next cycle.
// Backpressure: none; a start while running restarts the division.
module bn_seq_div #(
    parameter int AW = 40,
    parameter int DW = 5,
    parameter int QW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int            CW   = $clog2(AW);
    localparam logic [CW-1:0] LAST = CW'(AW - 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;

    logic [DW:0]   trial;
    logic [DW:0]   diff;
    logic          ge;

    // Trial subtraction: shift the next dividend bit into the remainder and test against divisor.
    always_comb begin
        trial = {rem_q, quo_q[AW-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = ~diff[DW];
    end

    // Next-state for the iteration registers; quotient bits shift in where dividend bits shift out.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (run_q) begin
            quo_d = {quo_q[AW-2:0], ge};
            rem_d = ge ? diff[DW-1:0] : trial[DW-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // Iteration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign done     = run_q && (cnt_q == LAST);
    assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/bn_mean_ctrl.sv
// Batch mean: accumulate num signed samples, divide by num, emit mean (optional rounding: BN_MEAN_ROUND_EN).
// Latency: out_valid 2*(IL+FL)+1 edges after the last accepted sample.
// Backpressure: in_ready only while accumulating; in_valid gaps stall indefinitely; start ignored when busy.
module bn_mean_ctrl
    import bn_pkg::*;
#(
    parameter int IL   = BN_IL,
    parameter int FL   = BN_FL,
    parameter int SIZE = 16
) (
    input  logic          clk,
    input  logic          rst,
    bn_mean_ctrl_if.slave bus
);

    localparam int                  W      = IL + FL;
    localparam int                  AW     = 2 * W;
    localparam int                  NW     = BN_NUM_W;
    localparam logic [NW-1:0]       SIZE_L = NW'(SIZE);

    state_e                state_q, state_d;
    logic signed [AW-1:0]  sum_q, sum_d;
    logic [NW-1:0]         cnt_q, cnt_d;
    logic [NW-1:0]         num_q, num_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_q, err_d;

    logic                  num_ok;
    logic                  accept;
    logic                  last_acc;
    logic                  div_start;
    logic                  div_done;
    logic signed [AW-1:0]  sum_nxt;
    logic [AW-1:0]         mag;
    logic [AW-1:0]         dividend;
    logic [W-1:0]          quo;

    assign num_ok   = (bus.num != '0) && (bus.num <= SIZE_L);
    assign accept   = (state_q == ST_ACCUM) && bus.in_valid;
    assign sum_nxt  = sum_q + {{W{bus.in_data[W-1]}}, bus.in_data};
    assign last_acc = accept && ((cnt_q + NW'(1)) == num_q);

    // Magnitude of the running sum including the sample being accepted, so the
    // divider can launch on the same edge that takes the final sample.
    always_comb begin
        mag = sum_nxt[AW-1] ? -sum_nxt : sum_nxt;
`ifdef BN_MEAN_ROUND_EN
        dividend = mag + AW'(num_q >> 1);
`else
        dividend = mag;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start && num_ok) state_d = ST_ACCUM;
            ST_ACCUM: if (last_acc)            state_d = ST_DIV;
            ST_DIV:   if (div_done)            state_d = ST_DONE;
            ST_DONE:                           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and divider launch.
    always_comb begin
        bus.in_ready = (state_q == ST_ACCUM);
        bus.busy     = (state_q != ST_IDLE);
        div_start    = last_acc;
    end

    // Datapath next values: batch setup, accumulation and sign-corrected result capture.
    always_comb begin
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (num_ok) begin
                        num_d = bus.num;
                        sum_d = '0;
                        cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    sum_d = sum_nxt;
                    cnt_d = cnt_q + NW'(1);
                end
            end
            ST_DONE: begin
                // Divider works on |sum|; restore the sign so truncation is toward zero.
                out_data_d  = sum_q[AW-1] ? -quo : quo;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;

    bn_seq_div #(
        .AW (AW),
        .DW (NW),
        .QW (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (num_q),
        .done     (div_done),
        .quotient (quo)
    );

endmodule

// File: tb/tb_bn_mean_ctrl.sv
// Self-checking bench for bn_mean_ctrl: directed and randomized batches against an arithmetic mean model.
// Latency: checks result strobe timing relative to the last accepted sample.
// Backpressure: random in_valid gaps and stray start requests while busy.
`timescale 1ns/1ps
module tb_bn_mean_ctrl;
    import bn_pkg::*;

    localparam int W   = BN_W;
    localparam int LAT = 2 * W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bn_mean_ctrl_if #(.IL(BN_IL), .FL(BN_FL)) bus ();

    bn_mean_ctrl #(.IL(BN_IL), .FL(BN_FL), .SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] samp [32];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mean of samp[0..n-1]: exact integer sum, magnitude divide, sign restored.
    function automatic logic [W-1:0] ref_mean(input int n);
        longint s;
        longint mag;
        longint q;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'($signed(samp[i]));
        mag = (s < 0) ? -s : s;
`ifdef BN_MEAN_ROUND_EN
        mag += n / 2;
`endif
        q = mag / n;
        if (s < 0) q = -q;
        return q[W-1:0];
    endfunction

    task automatic run_batch(input string tag, input int n, input int gap_pct,
                             input bit poke, input logic [W-1:0] exp);
        int idx;
        int budget;
        int k;
        bit seen;
        bit err_seen;
        idx      = 0;
        budget   = 0;
        err_seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 5'(n);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "/busy"}, 64'(bus.busy), 64'd1);
        while (idx < n && budget < 2000) begin
            bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
            bus.in_data  = samp[idx];
            if (poke && $urandom_range(3) == 0) begin
                bus.start = 1'b1;
                bus.num   = 5'($urandom_range(31));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            budget++;
            @(negedge clk);
            if (bus.err) err_seen = 1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check_eq({tag, "/accepts"}, 64'(idx), 64'(n));
        check_eq({tag, "/ready_drop"}, 64'(bus.in_ready), 64'd0);
        k    = 0;
        seen = 0;
        while (k < LAT + 10 && !seen) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) seen = 1;
            if (bus.err) err_seen = 1;
        end
        check_eq({tag, "/latency"}, 64'(k), 64'(LAT));
        check_eq({tag, "/data"}, 64'($unsigned(bus.out_data)), 64'(exp));
        check_eq({tag, "/no_err"}, 64'(err_seen), 64'd0);
        @(negedge clk);
        check_eq({tag, "/strobe_1cyc"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "/hold"}, 64'($unsigned(bus.out_data)), 64'(exp));
        check_eq({tag, "/idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_illegal(input string tag, input int n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 5'(n);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "/err"}, 64'(bus.err), 64'd1);
        check_eq({tag, "/busy"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_eq({tag, "/err_1cyc"}, 64'(bus.err), 64'd0);
        check_eq({tag, "/no_out"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "/still_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "/in_ready"}, 64'(bus.in_ready), 64'd0);
        check_eq({tag, "/busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "/out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "/err"}, 64'(bus.err), 64'd0);
        check_eq({tag, "/out_data"}, 64'($unsigned(bus.out_data)), 64'd0);
    endtask

    initial begin
        int n;
        bit out_seen;
        logic [W-1:0] exp37;

        bus.start    = 1'b0;
        bus.num      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset holds everything at zero even with active inputs.
        @(negedge clk);
        check_all_zero("rst0");
        bus.start    = 1'b1;
        bus.num      = 5'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_all_zero("rst1");
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        // Directed batches.
        samp[0] = 20'h10000; samp[1] = 20'h20000; samp[2] = 20'h30000; samp[3] = 20'h40000;
        run_batch("avg4", 4, 0, 0, 20'h28000);

        samp[0] = 20'hF0000; samp[1] = 20'hE0000;
        run_batch("neg2", 2, 0, 0, 20'hE8000);

        samp[0] = 20'h00001; samp[1] = 20'h00001; samp[2] = 20'h00000;
`ifdef BN_MEAN_ROUND_EN
        exp37 = 20'h00001;
`else
        exp37 = 20'h00000;
`endif
        run_batch("round3", 3, 0, 0, exp37);

        // Illegal lengths.
        run_illegal("num0", 0);
        run_illegal("num17", 17);
        run_illegal("numrnd", int'($urandom_range(31, 17)));

        // Full-size batch with stalls and stray starts.
        for (int i = 0; i < 16; i++) samp[i] = W'($urandom);
        run_batch("stall16", 16, 40, 1, ref_mean(16));

        // Randomized batches.
        for (int b = 0; b < 8; b++) begin
            n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) samp[i] = W'($urandom);
            run_batch($sformatf("rnd%0d", b), n, int'($urandom_range(50)), bit'($urandom_range(1)), ref_mean(n));
        end

        // Abort after two of four samples.
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 5'd4;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 20'h70000;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check_all_zero("abort");
        out_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid) out_seen = 1;
        end
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) out_seen = 1;
        end
        check_eq("abort/no_result", 64'(out_seen), 64'd0);
        samp[0] = 20'h50000;
        run_batch("post_abort", 1, 0, 0, 20'h50000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
